// File: rtl/ram_bridge.sv
// rtl/ram_bridge.sv - 32-bit cache word requests served from a byte-wide synchronous RAM
//
// Accepts one word request from the data cache and performs it as a sequence
// of single-byte accesses to an external synchronous RAM, one per cycle.
//
// Optional feature macro: RAM_BRIDGE_READ_SEL_EN
//   undefined : reads always fetch all four bytes of the word
//   defined   : reads fetch only the lanes set in ram_sel_i; other lanes read 0
//
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   ram_addr_i     request byte address (bits [1:0] ignored)
//   ram_we_i       1 = write, 0 = read
//   ram_sel_i      byte lanes, bit k = byte k (little-endian)
//   ram_data_i     write data
//   ram_ce_i       request valid, held stable until ram_done_o
//   ram_data_o     read data, valid in the done cycle and held until the next read completes
//   ram_busy_o     transfer in progress
//   ram_done_o     one-cycle completion pulse
//   mem_a_o        byte address to external RAM
//   mem_dout_o     byte write data
//   mem_wr_o       byte write strobe
//   mem_din_i      byte read data, valid the cycle after its address
module ram_bridge #(
    parameter int ADDR_WIDTH = 17
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           ram_addr_i,
    input  logic                  ram_we_i,
    input  logic [3:0]            ram_sel_i,
    input  logic [31:0]           ram_data_i,
    input  logic                  ram_ce_i,
    output logic [31:0]           ram_data_o,
    output logic                  ram_busy_o,
    output logic                  ram_done_o,
    output logic [ADDR_WIDTH-1:0] mem_a_o,
    output logic [7:0]            mem_dout_o,
    output logic                  mem_wr_o,
    input  logic [7:0]            mem_din_i
);

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

`ifdef RAM_BRIDGE_READ_SEL_EN
    localparam bit READ_SEL = 1'b1;
`else
    localparam bit READ_SEL = 1'b0;
`endif

    state_t                  state_q;
    logic [ADDR_WIDTH-3:0]   word_q;      // latched word address
    logic                    we_q;
    logic [31:0]             wdata_q;
    logic [3:0]              todo_q;      // lanes still to be issued
    logic                    issuing_q;   // a lane address is on the bus this cycle
    logic [1:0]              lane_q;      // lane currently on the bus
    logic                    pend_q;      // a read byte arrives on mem_din_i this cycle
    logic [1:0]              pend_lane_q; // lane that arriving byte belongs to
    logic [31:0]             cap_q;       // read word being assembled
    logic [31:0]             rdata_q;     // last completed read word
    logic [ADDR_WIDTH-1:0]   mem_a_q;
    logic [7:0]              mem_dout_q;
    logic                    mem_wr_q;
    logic                    busy_q;
    logic                    done_q;

    logic [3:0]              accept_mask;
    logic [3:0]              src_mask;
    logic [3:0]              rest_mask;
    logic [1:0]              next_lane;
    logic [ADDR_WIDTH-3:0]   src_word;
    logic [31:0]             src_wdata;
    logic                    src_we;
    logic [31:0]             cap_d;

    // Upper address bits alias away and the low two are word-offset bits.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{ram_addr_i[31:ADDR_WIDTH], ram_addr_i[1:0]};

    // In IDLE the next lane comes straight from the incoming request so the
    // first byte can be issued in the cycle right after acceptance.
    always_comb begin
        accept_mask = (ram_we_i || READ_SEL) ? ram_sel_i : 4'b1111;
        src_mask    = (state_q == IDLE) ? accept_mask : todo_q;
        src_word    = (state_q == IDLE) ? ram_addr_i[ADDR_WIDTH-1:2] : word_q;
        src_wdata   = (state_q == IDLE) ? ram_data_i : wdata_q;
        src_we      = (state_q == IDLE) ? ram_we_i : we_q;

        next_lane = 2'd0;
        if (src_mask[0])      next_lane = 2'd0;
        else if (src_mask[1]) next_lane = 2'd1;
        else if (src_mask[2]) next_lane = 2'd2;
        else if (src_mask[3]) next_lane = 2'd3;
        rest_mask = src_mask & ~(4'b0001 << next_lane);

        cap_d = cap_q;
        if (pend_q) begin
            cap_d[{pend_lane_q, 3'b000} +: 8] = mem_din_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            word_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            todo_q      <= '0;
            issuing_q   <= 1'b0;
            lane_q      <= '0;
            pend_q      <= 1'b0;
            pend_lane_q <= '0;
            cap_q       <= '0;
            rdata_q     <= '0;
            mem_a_q     <= '0;
            mem_dout_q  <= '0;
            mem_wr_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            mem_a_q     <= '0;
            mem_dout_q  <= '0;
            mem_wr_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            issuing_q   <= 1'b0;
            // A read address on the bus now yields its byte next cycle.
            pend_q      <= issuing_q && !we_q;
            pend_lane_q <= lane_q;
            cap_q       <= cap_d;

            case (state_q)
                IDLE: begin
                    if (ram_ce_i) begin
                        word_q  <= ram_addr_i[ADDR_WIDTH-1:2];
                        we_q    <= ram_we_i;
                        wdata_q <= ram_data_i;
                        if (!ram_we_i) begin
                            cap_q <= '0;
                        end
                        if (accept_mask == 4'b0000) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ram_we_i ? WR : RD;
                        end
                    end
                end
                RD, WR: begin
                    if (todo_q == 4'b0000) begin
                        // Full-word reads linger one cycle to capture lane 3;
                        // selective reads merge their last byte during DONE.
                        if (state_q == WR || READ_SEL || !issuing_q) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            if (state_q == RD && !READ_SEL) begin
                                rdata_q <= cap_d;
                            end
                        end else begin
                            busy_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    if (READ_SEL && !we_q) begin
                        rdata_q <= cap_d;
                    end
                end
                default: state_q <= IDLE;
            endcase

            // Issue the next lane on acceptance or while lanes remain.
            if ((state_q == IDLE && ram_ce_i && accept_mask != 4'b0000) ||
                ((state_q == RD || state_q == WR) && todo_q != 4'b0000)) begin
                mem_a_q    <= {src_word, next_lane};
                mem_wr_q   <= src_we;
                mem_dout_q <= src_we ? src_wdata[{next_lane, 3'b000} +: 8] : 8'h00;
                busy_q     <= 1'b1;
                issuing_q  <= 1'b1;
                lane_q     <= next_lane;
                todo_q     <= rest_mask;
            end
        end
    end

    assign mem_a_o    = mem_a_q;
    assign mem_dout_o = mem_dout_q;
    assign mem_wr_o   = mem_wr_q;
    assign ram_busy_o = busy_q;
    assign ram_done_o = done_q;

`ifdef RAM_BRIDGE_READ_SEL_EN
    assign ram_data_o = (state_q == DONE && !we_q) ? cap_d : rdata_q;
`else
    assign ram_data_o = rdata_q;
`endif

endmodule

// File: tb/tb_ram_bridge.sv
// tb/tb_ram_bridge.sv - self-checking bench for ram_bridge
module tb_ram_bridge;

    localparam int AW    = 17;
    localparam int MEMSZ = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   ram_addr_i;
    logic          ram_we_i;
    logic [3:0]    ram_sel_i;
    logic [31:0]   ram_data_i;
    logic          ram_ce_i;
    logic [31:0]   ram_data_o;
    logic          ram_busy_o;
    logic          ram_done_o;
    logic [AW-1:0] mem_a_o;
    logic [7:0]    mem_dout_o;
    logic          mem_wr_o;
    logic [7:0]    mem_din_i = 8'h00;

    ram_bridge #(.ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .ram_addr_i (ram_addr_i),
        .ram_we_i   (ram_we_i),
        .ram_sel_i  (ram_sel_i),
        .ram_data_i (ram_data_i),
        .ram_ce_i   (ram_ce_i),
        .ram_data_o (ram_data_o),
        .ram_busy_o (ram_busy_o),
        .ram_done_o (ram_done_o),
        .mem_a_o    (mem_a_o),
        .mem_dout_o (mem_dout_o),
        .mem_wr_o   (mem_wr_o),
        .mem_din_i  (mem_din_i)
    );

    always #5 clk = ~clk;

    // External byte RAM (what the DUT touches) and the bench's expected image.
    logic [7:0] ram     [MEMSZ];
    logic [7:0] ref_mem [MEMSZ];

    always @(posedge clk) begin
        mem_din_i <= ram[mem_a_o];
        if (mem_wr_o) ram[mem_a_o] = mem_dout_o;
    end

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] last_rd  = 32'h0;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] data;
        bit          b2b;
        int          exp_done;
        bit          chk_rd;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [AW-1:0] baddr(input logic [31:0] a, input int k);
        logic [1:0] kk;
        kk = k[1:0];
        return {a[AW-1:2], kk};
    endfunction

    function automatic int popcount4(input logic [3:0] s);
        return int'(s[0]) + int'(s[1]) + int'(s[2]) + int'(s[3]);
    endfunction

    // One request. Expected bus activity comes from the rules: reads touch
    // lanes 0..3 in cycles 1..4, writes touch the selected lanes in ascending
    // order in cycles 1..n, done lands in cycle exp_done.
    task automatic run_req(input logic [31:0] a, input logic we, input logic [3:0] sel,
                           input logic [31:0] d, input bit b2b, input int exp_done,
                           input bit chk_rd, input logic [31:0] exp_rd_tbl, input string tag);
        int          lanes[$];
        int          n;
        logic [31:0] exp_rd;
        logic [31:0] exp_a;
        logic [7:0]  exp_dout;
        logic        a_care;
        for (int k = 0; k < 4; k++) begin
            if (!we || sel[k]) lanes.push_back(k);
        end
        n = lanes.size();
        exp_rd = '0;
        if (!we) begin
            for (int k = 0; k < 4; k++) exp_rd[8*k +: 8] = ref_mem[baddr(a, k)];
            if (chk_rd) exp_rd = exp_rd_tbl;
            last_rd = exp_rd;
        end else begin
            foreach (lanes[i]) ref_mem[baddr(a, lanes[i])] = d[8*lanes[i] +: 8];
        end

        if (!b2b) begin
            @(negedge clk);
            check({tag, " idle"}, {61'd0, ram_busy_o, ram_done_o, mem_wr_o}, 64'd0);
        end
        ram_addr_i = a;
        ram_we_i   = we;
        ram_sel_i  = sel;
        ram_data_i = d;
        ram_ce_i   = 1'b1;
        if (b2b) @(posedge clk);
        @(posedge clk);
        for (int c = 1; c <= exp_done; c++) begin
            @(negedge clk);
            exp_a    = '0;
            exp_dout = '0;
            if (c <= n) begin
                exp_a = 32'(baddr(a, lanes[c-1]));
                if (we) exp_dout = d[8*lanes[c-1] +: 8];
            end
            a_care = !(!we && c > n && c < exp_done);
            check($sformatf("%s cycle%0d busy/done/wr/dout/a", tag, c),
                  {29'd0, ram_busy_o, ram_done_o, mem_wr_o, mem_dout_o,
                   a_care ? 32'(mem_a_o) : 32'd0},
                  {29'd0, c < exp_done, c == exp_done, we && c <= n, exp_dout, exp_a});
        end
        check({tag, " ram_data_o"}, {32'd0, ram_data_o}, {32'd0, last_rd});
        ram_ce_i = 1'b0;
    endtask

    initial begin
        logic        we;
        logic [3:0]  sel;
        logic [31:0] a;
        logic [31:0] d;
        bit          b2b;
        bit          saw_done;

        for (int i = 0; i < MEMSZ; i++) begin
            ram[i]     = 8'((i * 37 + 11) & 8'hff);
            ref_mem[i] = ram[i];
        end
        for (int k = 0; k < 4; k++) begin
            ram[32'h100 + k]   = 8'(8'h11 * (k + 1));
            ram[32'h1FFFC + k] = 8'(k + 1);
            ram[32'h4 + k]     = 8'(8'hA1 + 8'h11 * k);
            ram[32'h200 + k]   = 8'(8'h50 + k);
            ram[32'h104 + k]   = 8'(8'h61 + k);
        end
        for (int k = 0; k < 4; k++) begin
            ref_mem[32'h100 + k]   = ram[32'h100 + k];
            ref_mem[32'h1FFFC + k] = ram[32'h1FFFC + k];
            ref_mem[32'h4 + k]     = ram[32'h4 + k];
            ref_mem[32'h200 + k]   = ram[32'h200 + k];
            ref_mem[32'h104 + k]   = ram[32'h104 + k];
        end

        vecs[0] = '{32'h0000_0100, 1'b0, 4'b1111, 32'h0,          1'b0, 6, 1'b1, 32'h4433_2211};
        vecs[1] = '{32'h0000_0200, 1'b1, 4'b0101, 32'hAABB_CCDD,  1'b0, 3, 1'b0, 32'h0};
        vecs[2] = '{32'h0000_0300, 1'b1, 4'b0000, 32'h1234_5678,  1'b1, 1, 1'b0, 32'h0};
        vecs[3] = '{32'h0001_FFFC, 1'b0, 4'b1111, 32'h0,          1'b0, 6, 1'b1, 32'h0403_0201};
        vecs[4] = '{32'h0002_0004, 1'b0, 4'b1111, 32'h0,          1'b1, 6, 1'b1, 32'hD4C3_B2A1};
        vecs[5] = '{32'h0000_0200, 1'b0, 4'b1111, 32'h0,          1'b1, 6, 1'b1, 32'h53BB_51DD};
        vecs[6] = '{32'h0000_0104, 1'b1, 4'b1000, 32'h1234_5678,  1'b1, 2, 1'b0, 32'h0};
        vecs[7] = '{32'h0000_0104, 1'b0, 4'b0000, 32'h0,          1'b0, 6, 1'b1, 32'h1263_6261};
        vecs[8] = '{32'h0000_0400, 1'b1, 4'b1111, 32'hCAFE_F00D,  1'b1, 5, 1'b0, 32'h0};
        vecs[9] = '{32'h0000_0400, 1'b0, 4'b0011, 32'h0,          1'b1, 6, 1'b1, 32'hCAFE_F00D};

        rst        = 1'b1;
        ram_addr_i = '0;
        ram_we_i   = 1'b0;
        ram_sel_i  = '0;
        ram_data_i = '0;
        ram_ce_i   = 1'b0;
        repeat (2) @(negedge clk);
        check("reset outputs", {ram_data_o, 15'd0, mem_a_o},
              {32'd0, 32'd0});
        check("reset strobes", {56'd0, ram_busy_o, ram_done_o, mem_wr_o, mem_dout_o[4:0]}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("after reset dout", {56'd0, mem_dout_o}, 64'd0);

        foreach (vecs[i]) begin
            run_req(vecs[i].addr, vecs[i].we, vecs[i].sel, vecs[i].data, vecs[i].b2b,
                    vecs[i].exp_done, vecs[i].chk_rd, vecs[i].exp_rd, $sformatf("vec%0d", i));
        end
        check("ram 0x201 untouched", {56'd0, ram[32'h201]}, {56'd0, 8'h51});
        check("ram 0x203 untouched", {56'd0, ram[32'h203]}, {56'd0, 8'h53});

        // Reset during cycle 3 of a read: immediate clear, no done pulse.
        @(negedge clk);
        ram_addr_i = 32'h100; ram_we_i = 1'b0; ram_sel_i = 4'hF; ram_ce_i = 1'b1;
        @(posedge clk);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        ram_ce_i = 1'b0;
        #1;
        check("rst mid-read outputs",
              {ram_data_o, 7'd0, ram_busy_o, ram_done_o, mem_wr_o, mem_dout_o, 5'd0, mem_a_o[10:0]},
              64'd0);
        check("rst mid-read addr", {47'd0, mem_a_o}, 64'd0);
        saw_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (ram_done_o) saw_done = 1'b1;
        end
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (ram_done_o) saw_done = 1'b1;
        end
        check("no done after abort", {63'd0, saw_done}, 64'd0);
        last_rd = 32'h0;
        run_req(32'h100, 1'b0, 4'hF, 32'h0, 1'b0, 6, 1'b1, 32'h4433_2211, "read after rst");

        // Reset while the second write strobe is on the bus.
        @(negedge clk);
        ram_addr_i = 32'h500; ram_we_i = 1'b1; ram_sel_i = 4'hF;
        ram_data_i = 32'h0BAD_BEEF; ram_ce_i = 1'b1;
        @(posedge clk);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        ram_ce_i = 1'b0;
        #1;
        check("rst mid-write mem_wr_o", {63'd0, mem_wr_o}, 64'd0);
        ref_mem[32'h500] = 8'hEF;
        @(negedge clk);
        rst = 1'b0;
        last_rd = 32'h0;
        run_req(32'h500, 1'b0, 4'hF, 32'h0, 1'b0, 6, 1'b0, 32'h0, "read 0x500");

        // Randomized requests against the reference image, with aliasing.
        for (int i = 0; i < 40; i++) begin
            we  = 1'($urandom_range(0, 1));
            sel = 4'($urandom);
            a   = $urandom & 32'h000F_FFFF;
            d   = $urandom;
            b2b = 1'($urandom_range(0, 1));
            run_req(a, we, sel, d, b2b, we ? popcount4(sel) + 1 : 6, 1'b0, 32'h0,
                    $sformatf("rand%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
